// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch port
//   (read-only) and the MEM-stage data port (read/write). One requester is
//   granted at a time. The memory request is registered and held until
//   mem_ack_i. The data port has priority when the arbiter is idle. On an
//   ack, the other port is granted directly if it is requesting, so under
//   contention the two ports alternate. A watchdog forces completion and
//   sets a sticky error when the memory stops answering.
//
// Ports
//   clk_i, rst_i         clock (rising edge), asynchronous active-low reset
//   i_req_i/i_addr_i     fetch request (level) and address
//   i_flush_i            discard the in-flight fetch result
//   i_rdata_o/i_valid_o  fetch data, qualified by the one-cycle valid
//   i_stall_o            fetch pending and not completing this cycle
//   d_req_i/d_we_i       data request (level) and write enable
//   d_addr_i/d_wdata_i   data address and write data
//   d_rdata_o/d_valid_o  data read data, qualified by the one-cycle valid
//   d_stall_o            data access pending and not completing this cycle
//   mem_*_o              registered memory request, we, address, write data
//   mem_rdata_i          memory read data, valid together with mem_ack_i
//   mem_ack_i            memory completion pulse
//   err_o                sticky watchdog error
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_req_i,
    input  logic [AW-1:0] i_addr_i,
    input  logic          i_flush_i,
    output logic [DW-1:0] i_rdata_o,
    output logic          i_valid_o,
    output logic          i_stall_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_valid_o,
    output logic          d_stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i,
    output logic          err_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        state, state_d;
    logic          req_d, we_d, err_d, drop, drop_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [CW-1:0] wd_cnt, cnt_d;
    logic          wd_fire, done, grant_i, grant_d, ivld;

    // The watchdog fires on the TIMEOUT-th consecutive busy cycle without ack;
    // that cycle itself is the forced completion.
    assign wd_fire = (TIMEOUT > 0) && (state != IDLE) && !mem_ack_i && (wd_cnt == WD_LAST);
    assign done    = mem_ack_i | wd_fire;

    always_comb begin
        state_d   = state;
        req_d     = mem_req_o;
        we_d      = mem_we_o;
        addr_d    = mem_addr_o;
        wdata_d   = mem_wdata_o;
        err_d     = err_o;
        drop_d    = drop;
        cnt_d     = wd_cnt;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        ivld      = 1'b0;
        i_valid_o = 1'b0;
        d_valid_o = 1'b0;
        i_rdata_o = '0;
        d_rdata_o = '0;

        case (state)
            IDLE: begin
                if (d_req_i) begin
                    grant_d = 1'b1;
                end else if (i_req_i) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I: begin
                if (done) begin
                    ivld      = ~drop & ~i_flush_i;
                    i_valid_o = ivld;
                    if (ivld && mem_ack_i) begin
                        i_rdata_o = mem_rdata_i;
                    end
                    drop_d = 1'b0;
                    err_d  = err_o | wd_fire;
                    // The completing fetch is excluded; only data can follow.
                    if (d_req_i) begin
                        grant_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end else begin
                    cnt_d = wd_cnt + CW'(1);
                    if (i_flush_i) begin
                        drop_d = 1'b1;
                    end
                end
            end
            BUSY_D: begin
                if (done) begin
                    d_valid_o = 1'b1;
                    if (mem_ack_i && !mem_we_o) begin
                        d_rdata_o = mem_rdata_i;
                    end
                    err_d = err_o | wd_fire;
                    if (i_req_i) begin
                        grant_i = 1'b1;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end else begin
                    cnt_d = wd_cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (grant_d) begin
            state_d = BUSY_D;
            req_d   = 1'b1;
            we_d    = d_we_i;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
            cnt_d   = '0;
        end else if (grant_i) begin
            state_d = BUSY_I;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = i_addr_i;
            wdata_d = '0;
            cnt_d   = '0;
            drop_d  = 1'b0;
        end
    end

    // Gated by reset so that every output is low while reset is held.
    assign i_stall_o = rst_i & i_req_i & ~i_valid_o;
    assign d_stall_o = rst_i & d_req_i & ~d_valid_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            err_o       <= 1'b0;
            drop        <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            state       <= state_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
            err_o       <= err_d;
            drop        <= drop_d;
            wd_cnt      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          i_req_i, i_flush_i, i_valid_o, i_stall_o;
    logic [AW-1:0] i_addr_i;
    logic [DW-1:0] i_rdata_o;
    logic          d_req_i, d_we_i, d_valid_o, d_stall_o;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i, d_rdata_o;
    logic          mem_req_o, mem_we_o, mem_ack_i, err_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_flush_i(i_flush_i),
        .i_rdata_o(i_rdata_o), .i_valid_o(i_valid_o), .i_stall_o(i_stall_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_stall_o(d_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory environment: 16-word store, ack after a chosen latency.
    logic [DW-1:0] mem [16];
    bit  mm_busy   = 1'b0;
    int  mm_age    = 0;
    int  mm_lat    = 0;
    int  lat_fixed = -1;
    bit  hang      = 1'b0;

    // Reference model: which port owns the memory and what it asked for.
    typedef enum int {NONE, FETCH, DATA} who_t;
    who_t          cur    = NONE;
    logic [AW-1:0] c_addr = '0;
    logic          c_we   = 1'b0;
    logic [DW-1:0] c_wdata = '0;
    int            c_age  = 0;
    bit            c_drop = 1'b0;
    bit            e_err  = 1'b0;

    // Observations from the last stepped cycle.
    logic          obs_iv, obs_dv, obs_is, obs_ds, obs_ack;
    logic [DW-1:0] obs_ir, obs_dr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cur     = NONE;
        c_age   = 0;
        c_drop  = 1'b0;
        e_err   = 1'b0;
        mm_busy = 1'b0;
    endtask

    // One clock cycle. Entered and left at posedge+1 with inputs already set.
    task automatic cyc();
        logic          ack, to, done, e_iv, e_dv;
        logic [DW-1:0] rd, e_ir, e_dr;
        who_t          nxt;
        ack = 1'b0;
        if (mem_req_o === 1'b1) begin
            if (!mm_busy) begin
                mm_busy = 1'b1;
                mm_age  = 0;
                mm_lat  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
            end
            ack = !hang && (mm_age == mm_lat);
        end
        rd = (ack && !mem_we_o) ? mem[mem_addr_o[5:2]] : $urandom;
        mem_ack_i   = ack;
        mem_rdata_i = rd;
        #1;

        to   = (cur != NONE) && !ack && (c_age == TO - 1);
        done = (cur != NONE) && (ack || to);
        e_iv = done && (cur == FETCH) && !c_drop && !i_flush_i;
        e_dv = done && (cur == DATA);
        e_ir = (e_iv && ack) ? rd : '0;
        e_dr = (e_dv && ack && !c_we) ? rd : '0;

        chk("mem_req_o", mem_req_o, (cur != NONE));
        if (cur != NONE) begin
            chk("mem_addr_o", mem_addr_o, c_addr);
            chk("mem_we_o", mem_we_o, c_we);
            if (c_we) chk("mem_wdata_o", mem_wdata_o, c_wdata);
        end
        chk("i_valid_o", i_valid_o, e_iv);
        chk("d_valid_o", d_valid_o, e_dv);
        chk("i_rdata_o", i_rdata_o, e_ir);
        chk("d_rdata_o", d_rdata_o, e_dr);
        chk("i_stall_o", i_stall_o, i_req_i && !e_iv);
        chk("d_stall_o", d_stall_o, d_req_i && !e_dv);
        chk("err_o", err_o, e_err);

        obs_iv = i_valid_o; obs_dv = d_valid_o; obs_is = i_stall_o; obs_ds = d_stall_o;
        obs_ir = i_rdata_o; obs_dr = d_rdata_o; obs_ack = ack;

        if (ack && mem_we_o) mem[mem_addr_o[5:2]] = mem_wdata_o;
        if (mm_busy) begin
            if (ack || mm_age == TO - 1) mm_busy = 1'b0;
            else mm_age++;
        end

        if (to) e_err = 1'b1;
        if (done || cur == NONE) begin
            nxt = NONE;
            if (cur == FETCH) begin
                if (d_req_i) nxt = DATA;
            end else if (cur == DATA) begin
                if (i_req_i) nxt = FETCH;
            end else if (d_req_i) begin
                nxt = DATA;
            end else if (i_req_i) begin
                nxt = FETCH;
            end
            if (nxt == DATA) begin
                c_addr = d_addr_i; c_we = d_we_i; c_wdata = d_wdata_i;
            end else if (nxt == FETCH) begin
                c_addr = i_addr_i; c_we = 1'b0;
            end
            cur    = nxt;
            c_age  = 0;
            c_drop = 1'b0;
        end else begin
            c_age++;
            if (cur == FETCH && i_flush_i) c_drop = 1'b1;
        end

        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
    endtask

    task automatic wait_fetch(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            if (obs_iv) got = 1'b1;
        end
        i_req_i = 1'b0;
        chk(tag, got, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (cur == NONE && mem_req_o === 1'b0) break;
            cyc();
        end
        chk("drain_idle", mem_req_o, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int  n, stalls, ncomp, run_i, run_d, max_i, max_d;
        int  order [4];
        bit  got, flushed;

        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        rst_i = 1'b0;
        i_req_i = 1'b1; i_addr_i = '0; i_flush_i = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;

        // Reset state, with requests asserted during reset.
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, '0);
        chk("rst_mem_wdata", mem_wdata_o, '0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_i_stall", i_stall_o, 1'b0);
        chk("rst_d_stall", d_stall_o, 1'b0);
        chk("rst_valids", {i_valid_o, d_valid_o}, 2'b00);
        i_req_i = 1'b0; d_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Fetch only, ack two cycles after mem_req_o rises.
        mem[0] = 32'hDEADBEEF;
        lat_fixed = 2;
        i_req_i = 1'b1; i_addr_i = 32'h100;
        n = 0; stalls = 0; got = 1'b0;
        while (!got && n < 10) begin
            cyc();
            n++;
            if (n == 1) chk("t1_mem_addr", mem_addr_o, 32'h100);
            if (obs_is) stalls++;
            if (obs_iv) begin
                got = 1'b1;
                chk("t1_rdata", obs_ir, 32'hDEADBEEF);
            end
        end
        i_req_i = 1'b0;
        chk("t1_done", got, 1'b1);
        chk("t1_stall_cycles", stalls, 3);
        chk("t1_req_dropped", mem_req_o, 1'b0);

        // Simultaneous requests: data write first, fetch follows without a gap.
        i_req_i = 1'b1; i_addr_i = 32'h104;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h40; d_wdata_i = 32'h5;
        cyc();
        chk("t2_we", mem_we_o, 1'b1);
        chk("t2_wdata", mem_wdata_o, 32'h5);
        chk("t2_addr", mem_addr_o, 32'h40);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cyc();
            if (obs_dv) begin
                got = 1'b1;
                chk("t2_d_rdata_write", obs_dr, '0);
            end
        end
        d_req_i = 1'b0;
        chk("t2_d_done", got, 1'b1);
        chk("t2_no_gap", mem_req_o, 1'b1);
        chk("t2_fetch_addr", mem_addr_o, 32'h104);
        wait_fetch("t2_i_done");
        drain();

        // Continuous contention: strict alternation starting with data.
        i_req_i = 1'b1; i_addr_i = 32'hC;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40;
        ncomp = 0; run_i = 0; run_d = 0; max_i = 0; max_d = 0;
        for (int k = 0; k < 40 && ncomp < 4; k++) begin
            cyc();
            run_i = obs_is ? run_i + 1 : 0;
            run_d = obs_ds ? run_d + 1 : 0;
            if (run_i > max_i) max_i = run_i;
            if (run_d > max_d) max_d = run_d;
            if (obs_dv) begin
                if (ncomp == 0) chk("t3_read_back", obs_dr, 32'h5);
                if (ncomp < 4) order[ncomp] = 2;
                ncomp++;
                if (ncomp > 2) d_req_i = 1'b0;
                else d_addr_i = d_addr_i + 32'h4;
            end
            if (obs_iv) begin
                if (ncomp < 4) order[ncomp] = 1;
                ncomp++;
                if (ncomp > 2) i_req_i = 1'b0;
                else i_addr_i = i_addr_i + 32'h4;
            end
        end
        i_req_i = 1'b0; d_req_i = 1'b0;
        chk("t3_count", ncomp, 4);
        chk("t3_order0", order[0], 2);
        chk("t3_order1", order[1], 1);
        chk("t3_order2", order[2], 2);
        chk("t3_order3", order[3], 1);
        chk("t3_i_stall_bound", (max_i <= 6), 1'b1);
        chk("t3_d_stall_bound", (max_d <= 6), 1'b1);
        drain();

        // Flush in the second busy cycle, then a new fetch address.
        i_req_i = 1'b1; i_addr_i = 32'h180;
        cyc();
        cyc();
        i_flush_i = 1'b1;
        cyc();
        i_flush_i = 1'b0;
        i_addr_i = 32'h200;
        cyc();
        chk("t4_ack_seen", obs_ack, 1'b1);
        chk("t4_dropped", obs_iv, 1'b0);
        cyc();
        chk("t4_new_req", mem_req_o, 1'b1);
        chk("t4_new_addr", mem_addr_o, 32'h200);
        wait_fetch("t4_refetch_done");
        drain();

        // Hung memory on a data read: forced completion on the 4th busy cycle.
        hang = 1'b1;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h8;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("t5_d_valid", obs_dv, (k == 4));
        end
        chk("t5_forced_rdata", obs_dr, '0);
        d_req_i = 1'b0;
        hang = 1'b0;
        chk("t5_err_set", err_o, 1'b1);
        chk("t5_req_dropped", mem_req_o, 1'b0);
        cyc();
        chk("t5_err_sticky", err_o, 1'b1);
        lat_fixed = -1;
        i_req_i = 1'b1; i_addr_i = 32'h4;
        wait_fetch("t5_fetch_after_error");
        chk("t5_err_still_set", err_o, 1'b1);
        drain();

        // Asynchronous reset in the middle of a data access.
        lat_fixed = 2;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h10; d_wdata_i = 32'h1234;
        cyc();
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_req_async", mem_req_o, 1'b0);
        chk("t6_err_async", err_o, 1'b0);
        chk("t6_addr_async", mem_addr_o, '0);
        d_req_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t6_idle_after", mem_req_o, 1'b0);
        lat_fixed = -1;
        i_req_i = 1'b1; i_addr_i = 32'h20;
        wait_fetch("t6_fetch_after_reset");
        drain();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            i_flush_i = i_req_i && ($urandom_range(0, 9) == 0);
            flushed = i_flush_i;
            cyc();
            i_flush_i = 1'b0;
            if (!i_req_i || obs_iv || flushed) begin
                i_req_i  = 1'($urandom_range(0, 1));
                i_addr_i = AW'($urandom_range(0, 15) << 2);
            end
            if (!d_req_i || obs_dv) begin
                d_req_i   = ($urandom_range(0, 4) < 2);
                d_we_i    = 1'($urandom_range(0, 1));
                d_addr_i  = AW'($urandom_range(0, 15) << 2);
                d_wdata_i = $urandom;
            end
        end
        i_req_i = 1'b0; d_req_i = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
